// File: rtl/mux_sel_arbiter_16_if.sv
// Bundle of request, handshake and select signals between the 16-source
// round-robin arbiter (master side) and its sources and consumer (slave side).
interface mux_sel_arbiter_16_if #(
  parameter int N_SRC = 16,
  parameter int SEL_W = 4
);
  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] last;
  logic             out_ready;
  logic [SEL_W-1:0] sel;
  logic             out_valid;
  logic [N_SRC-1:0] gnt;
  logic             busy;

  // Arbiter side: consumes requests and drives the select and handshake.
  modport master (
    input  req,
    input  last,
    input  out_ready,
    output sel,
    output out_valid,
    output gnt,
    output busy
  );

  // Environment side: sources and consumer drive requests and ready.
  modport slave (
    output req,
    output last,
    output out_ready,
    input  sel,
    input  out_valid,
    input  gnt,
    input  busy
  );
endinterface

// File: rtl/mux_sel_arbiter_16.sv
// Round-robin arbiter producing the registered select of a 32-bit 16:1 mux.
// A granted source keeps the select for its whole burst; the burst ends on an
// accepted beat flagged last, or when the source stops requesting for too
// long. Every burst is followed by one idle bubble cycle.
module mux_sel_arbiter_16 #(
  parameter int N_SRC   = 16,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 8,
  parameter int TO_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_sel_arbiter_16_if.master  bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [0:0]       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  logic [SEL_W-1:0] winner;
  logic [SEL_W-1:0] probe;
  logic             found;
  logic             busy;
  logic             src_req;
  logic             out_valid;
  logic             accept;

  assign busy      = (state_q == ST_GRANT);
  assign src_req   = bus.req[sel_q];
  assign out_valid = busy & src_req;
  assign accept    = out_valid & bus.out_ready;

  assign bus.sel       = sel_q;
  assign bus.busy      = busy;
  assign bus.out_valid = out_valid;
  assign bus.gnt       = accept ? ({{(N_SRC-1){1'b0}}, 1'b1} << sel_q) : '0;

  // Search requests starting at ptr and wrapping; the first set bit wins.
  always_comb begin
    winner = ptr_q;
    probe  = ptr_q;
    found  = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      probe = ptr_q + SEL_W'(k);
      if (!found && bus.req[probe]) begin
        winner = probe;
        found  = 1'b1;
      end
    end
  end

  // Grant/hold/release decisions; select only moves when leaving IDLE.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    to_cnt_d = to_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          sel_d    = winner;
          to_cnt_d = '0;
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          to_cnt_d = '0;
          if (bus.last[sel_q]) begin
            ptr_d   = sel_q + SEL_W'(1);
            state_d = ST_IDLE;
          end
        end else if (!src_req) begin
          if ((TIMEOUT != 0) && (to_cnt_q == TO_LAST)) begin
            ptr_d   = sel_q + SEL_W'(1);
            state_d = ST_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset clears everything at once, even mid-burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      ptr_q    <= '0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      to_cnt_q <= to_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter_16.sv
// Bench for the 16-source round-robin mux select arbiter: a behavioural model
// of the arbitration rules predicts every cycle under directed and random
// traffic; a second instance has the drop timeout disabled.
module tb_mux_sel_arbiter_16;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mux_sel_arbiter_16_if #(.N_SRC(16), .SEL_W(4)) bus ();
  mux_sel_arbiter_16_if #(.N_SRC(16), .SEL_W(4)) bus0 ();

  mux_sel_arbiter_16 #(.N_SRC(16), .SEL_W(4), .TIMEOUT(TO), .TO_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mux_sel_arbiter_16 #(.N_SRC(16), .SEL_W(4), .TIMEOUT(0), .TO_W(4)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: pointer, current owner, burst flag, drop count.
  int m_ptr;
  int m_cur;
  bit m_active;
  int m_drops;

  // Packed view {busy, out_valid, sel, gnt}.
  logic [21:0] exp_v;
  logic [21:0] obs_v;

  function automatic int rr_winner(input int p, input logic [15:0] r);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return p;
  endfunction

  task automatic model_reset();
    m_ptr    = 0;
    m_cur    = 0;
    m_active = 0;
    m_drops  = 0;
  endtask

  task automatic reset_dut();
    rst_n          = 1'b0;
    bus.req        = '0;
    bus.last       = '0;
    bus.out_ready  = 1'b0;
    bus0.req       = '0;
    bus0.last      = '0;
    bus0.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Wait for the falling edge, form the model's expectation, capture the DUT.
  task automatic predict();
    logic        e_valid;
    logic [15:0] e_gnt;
    @(negedge clk);
    e_valid = m_active && bus.req[m_cur];
    e_gnt   = '0;
    if (e_valid && bus.out_ready) e_gnt[m_cur] = 1'b1;
    exp_v = {m_active, e_valid, 4'(m_cur), e_gnt};
    obs_v = {bus.busy, bus.out_valid, bus.sel, bus.gnt};
  endtask

  // Apply the arbitration rules for this cycle, then step past the edge.
  task automatic advance();
    bit acc;
    acc = m_active && bus.req[m_cur] && bus.out_ready;
    if (!m_active) begin
      if (bus.req != 16'h0000) begin
        m_cur    = rr_winner(m_ptr, bus.req);
        m_active = 1;
        m_drops  = 0;
      end
    end else if (acc) begin
      m_drops = 0;
      if (bus.last[m_cur]) begin
        m_ptr    = (m_cur + 1) % 16;
        m_active = 0;
      end
    end else if (!bus.req[m_cur]) begin
      if (m_drops == TO - 1) begin
        m_ptr    = (m_cur + 1) % 16;
        m_active = 0;
      end else begin
        m_drops++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req       = 16'hFFFF;
    bus.last      = 16'hFFFF;
    bus.out_ready = 1'b1;
    bus0.req      = '0;
    bus0.last     = '0;
    bus0.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs_v = {bus.busy, bus.out_valid, bus.sel, bus.gnt};
    checks++;
    if (obs_v !== 22'h0) begin
      errors++;
      $display("[TB] FAIL reset_hold: got %h expected %h", obs_v, 22'h0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    predict();
    checks++;
    if (obs_v !== exp_v || bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_cycle1: got %h expected %h", obs_v, exp_v);
    end
    advance();
    predict();
    checks++;
    if (obs_v !== exp_v || bus.sel !== 4'd0 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_cycle2: got %h expected %h", obs_v, exp_v);
    end
    advance();
  endtask

  task automatic test_fairness();
    logic [15:0] gseq[4];
    logic [15:0] gexp[4];
    int n;
    gexp[0] = 16'h0001; gexp[1] = 16'h8000;
    gexp[2] = 16'h0001; gexp[3] = 16'h8000;
    n = 0;
    reset_dut();
    bus.req       = 16'h8001;
    bus.out_ready = 1'b1;
    bus.last      = 16'hFFFF;
    for (int c = 0; c < 8; c++) begin
      predict();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL fairness_cycle%0d: got %h expected %h", c, obs_v, exp_v);
      end
      if (bus.gnt != 16'h0000 && n < 4) begin
        gseq[n] = bus.gnt;
        n++;
      end
      advance();
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("[TB] FAIL fairness_count: got %0d expected %0d", n, 4);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (gseq[i] !== gexp[i]) begin
        errors++;
        $display("[TB] FAIL fairness_order%0d: got %h expected %h", i, gseq[i], gexp[i]);
      end
    end
  endtask

  task automatic test_wraparound();
    bus.req       = 16'h0006;
    bus.out_ready = 1'b1;
    bus.last      = 16'hFFFF;
    predict();
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("[TB] FAIL wrap_idle: got %h expected %h", obs_v, exp_v);
    end
    advance();
    predict();
    checks++;
    if (obs_v !== exp_v || bus.sel !== 4'd1 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_sel: got %h expected %h", obs_v, exp_v);
    end
    advance();
  endtask

  task automatic test_burst_hold();
    int beats;
    reset_dut();
    bus.req       = 16'h0008;
    bus.out_ready = 1'b0;
    bus.last      = '0;
    predict();
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("[TB] FAIL burst_idle: got %h expected %h", obs_v, exp_v);
    end
    advance();
    bus.req = 16'hFFFF;
    beats = 0;
    for (int c = 0; c < 20 && beats < 4; c++) begin
      bus.out_ready = (c % 2 == 0);
      bus.last      = (beats == 3) ? 16'hFFFF : 16'h0000;
      predict();
      checks++;
      if (obs_v !== exp_v || bus.sel !== 4'd3) begin
        errors++;
        $display("[TB] FAIL burst_hold%0d: got %h expected %h", c, obs_v, exp_v);
      end
      if (bus.gnt == 16'h0008) beats++;
      advance();
    end
    checks++;
    if (beats !== 4) begin
      errors++;
      $display("[TB] FAIL burst_beats: got %0d expected %0d", beats, 4);
    end
    bus.out_ready = 1'b1;
    bus.last      = '0;
    predict();
    checks++;
    if (obs_v !== exp_v || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL burst_bubble: got %h expected %h", obs_v, exp_v);
    end
    advance();
    predict();
    checks++;
    if (obs_v !== exp_v || bus.sel !== 4'd4) begin
      errors++;
      $display("[TB] FAIL burst_next: got %h expected %h", obs_v, exp_v);
    end
    advance();
  endtask

  task automatic test_random();
    logic [31:0] r;
    int density;
    reset_dut();
    density = 0;
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) density = $urandom_range(0, 2);
      r = $urandom;
      case (density)
        0:       bus.req = r[15:0];
        1:       bus.req = r[15:0] & r[31:16];
        default: bus.req = r[15:0] & r[31:16] & 16'($urandom) & 16'($urandom);
      endcase
      bus.last      = 16'($urandom) & 16'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      predict();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL random_cycle%0d: got %h expected %h", c, obs_v, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_timeout();
    int drops;
    reset_dut();
    bus.req       = 16'h0020;
    bus.out_ready = 1'b1;
    bus.last      = '0;
    predict();
    advance();
    predict();
    checks++;
    if (obs_v !== exp_v || bus.gnt !== 16'h0020) begin
      errors++;
      $display("[TB] FAIL timeout_beat1: got %h expected %h", obs_v, exp_v);
    end
    advance();
    bus.req = 16'hFFDF;
    drops = 0;
    for (int c = 0; c < 12; c++) begin
      predict();
      checks++;
      if (obs_v !== exp_v || bus.gnt !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL timeout_drop%0d: got %h expected %h", c, obs_v, exp_v);
      end
      if (!bus.busy) break;
      drops++;
      advance();
    end
    advance();
    checks++;
    if (drops !== TO) begin
      errors++;
      $display("[TB] FAIL timeout_len: got %0d expected %0d", drops, TO);
    end
    predict();
    checks++;
    if (obs_v !== exp_v || bus.sel !== 4'd6) begin
      errors++;
      $display("[TB] FAIL timeout_ptr: got %h expected %h", obs_v, exp_v);
    end
    advance();
  endtask

  task automatic test_timeout_disabled();
    logic [21:0] o0;
    reset_dut();
    bus0.req       = 16'h0020;
    bus0.out_ready = 1'b1;
    bus0.last      = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bus0.gnt !== 16'h0020) begin
      errors++;
      $display("[TB] FAIL notimeout_beat1: got %h expected %h", bus0.gnt, 16'h0020);
    end
    @(posedge clk);
    #1 bus0.req = 16'hFFDF;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      o0 = {bus0.busy, bus0.out_valid, bus0.sel, bus0.gnt};
      checks++;
      if (o0 !== {1'b1, 1'b0, 4'd5, 16'h0000}) begin
        errors++;
        $display("[TB] FAIL notimeout_hold%0d: got %h expected %h", c, o0,
                 {1'b1, 1'b0, 4'd5, 16'h0000});
      end
    end
    bus0.req = '0;
  endtask

  task automatic test_async_reset();
    reset_dut();
    bus.req       = 16'h0004;
    bus.out_ready = 1'b0;
    bus.last      = '0;
    predict();
    advance();
    predict();
    checks++;
    if (obs_v !== exp_v || bus.out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_pre: got %h expected %h", obs_v, exp_v);
    end
    #2 rst_n = 1'b0;
    #1;
    obs_v = {bus.busy, bus.out_valid, bus.sel, bus.gnt};
    checks++;
    if (obs_v !== 22'h0) begin
      errors++;
      $display("[TB] FAIL async_clear: got %h expected %h", obs_v, 22'h0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    predict();
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("[TB] FAIL async_after: got %h expected %h", obs_v, exp_v);
    end
    advance();
  endtask

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    rst_n = 1'b0;
    test_reset();
    test_fairness();
    test_wraparound();
    test_burst_hold();
    test_random();
    test_timeout();
    test_timeout_disabled();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter_16.md
Name: mux_sel_arbiter_16

Overview:
- Round-robin arbiter that drives the 4-bit select of the 32-bit 16:1 output mux.
- Sources 0..15 request access; the block grants one source at a time and holds sel stable for a multi-beat burst.
- It issues a valid/ready handshake toward the consumer of the mux output, and pulses a per-source accept strobe.
- Sits directly upstream of the mux; mux data is qualified by out_valid.

Parameters:
- N_SRC, 16, number of sources; fixed to match the 16:1 mux. Other values are unsupported.
- SEL_W, 4, select width; must equal log2(N_SRC).
- TIMEOUT, 8, idle cycles allowed inside a burst with req dropped before forced release; 0 disables the timeout.
- TO_W, 4, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  Clock, rising edge.
- rst_n  input  1  Reset, asynchronous, active-low.
- req  input  16  Per-source request; bit i high means source i presents valid data on mux input i.
- last  input  16  Per-source last-beat flag; sampled only for the granted source.
- out_ready  input  1  Consumer accepts a beat when high together with out_valid.
- sel  output  4  Registered select to the mux; stable for the whole burst.
- out_valid  output  1  Mux output holds a valid beat.
- gnt  output  16  One-hot accept strobe: bit sel is high in the cycle a beat is accepted.
- busy  output  1  High while in GRANT.

Behaviour:
- Reset (async assert, sync deassert by the driver):
  - sel=0, ptr=0, state=IDLE, to_cnt=0.
  - Outputs out_valid=0, gnt=0, busy=0.
- ptr is the round-robin start index.
  - Priority search runs ptr, ptr+1, ..., ptr+15, wrapping mod 16.
  - The first set req bit wins.
- IDLE:
  - If req==0: stay in IDLE, sel unchanged.
  - Otherwise: sel<=winner, to_cnt<=0, go to GRANT.
  - Latency from req seen in IDLE to out_valid is 1 cycle.
- GRANT:
  - busy=1; out_valid=req[sel] (combinational).
  - sel must not change while in GRANT.
- Beat accept: out_valid && out_ready.
  - gnt[sel]=1 in that cycle (combinational); all other gnt bits are 0.
  - to_cnt<=0.
- Burst end: a beat is accepted with last[sel]=1.
  - ptr<=sel+1 (wraps 15->0); go to IDLE.
  - One bubble cycle follows each burst; there is no back-to-back grant.
- Stall: out_valid=1, out_ready=0.
  - Hold state; to_cnt is not incremented (this is a consumer stall, not a source stall).
- Source drop: req[sel]=0 in GRANT.
  - to_cnt increments each such cycle.
  - If TIMEOUT!=0 and to_cnt reaches TIMEOUT-1 in a drop cycle: ptr<=sel+1, go to IDLE (forced release).
  - If TIMEOUT=0: the burst holds indefinitely.
- If req[sel] returns before timeout, to_cnt keeps its value until the next accept resets it.
- last is ignored when no beat is accepted.
- Requests from other sources never preempt an active burst.
- Reset mid-burst: immediate return to reset values, all outputs low, ptr=0.

Test Plan:
- Reset with req=16'hFFFF held: out_valid=0, sel=0. After release: cycle 1 → IDLE picks 0; cycle 2 → sel=0, out_valid=1.
- Fairness: req=16'h8001, out_ready=1, last=all ones → grant order 0,15,0,15 with one bubble between each; gnt alternates 16'h0001 / 16'h8000.
- Wrap-around: after source 15 finishes, req=16'h0006 → sel=1 (search restarts from 0).
- Burst hold: source 3 sends 4 beats, last on beat 4; out_ready toggles 1,0,1,0,...; req=16'hFFFF throughout → sel stays 3 until the 4th gnt[3], then next grant is source 4.
- Timeout: TIMEOUT=8, source 5 granted, req[5] drops after beat 1 → after 8 drop cycles state returns to IDLE, ptr=6, no gnt pulse. With TIMEOUT=0 → holds for ≥100 cycles.
- Async reset asserted mid-burst between clock edges → sel, out_valid, gnt and busy clear immediately, without waiting for clk.
